// File: rtl/panic_mat_cfg_arbiter.sv
// Round-robin arbiter that shares the PANIC MAT config port among NUM_REQ requesters.
// Optional per-requester write / hold statistics are enabled by PANIC_MAT_CFG_STATS_EN.
`ifndef MATCH_KEY_WIDTH
`define MATCH_KEY_WIDTH 32
`endif
`ifndef MAT_ADDR_WIDTH
`define MAT_ADDR_WIDTH 10
`endif

module panic_mat_cfg_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int KEY_WIDTH   = `MATCH_KEY_WIDTH,
  parameter int VALUE_WIDTH = 128,
  parameter int ADDR_WIDTH  = `MAT_ADDR_WIDTH,
  parameter int GAP_CYCLES  = 1,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             s_req_valid,
  output logic [NUM_REQ-1:0]             s_req_ready,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   s_req_key,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] s_req_value,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_req_addr,
  input  logic                           cfg_hold,
  output logic                           config_mat_en,
  output logic [KEY_WIDTH-1:0]           config_mat_key,
  output logic [VALUE_WIDTH-1:0]         config_mat_value,
  output logic [ADDR_WIDTH-1:0]          config_mat_addr,
  output logic                           busy,
  output logic [IDX_W-1:0]               last_grant
`ifdef PANIC_MAT_CFG_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]          stat_wr_cnt,
  output logic [31:0]                    stat_hold_cycles
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_GAP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              gap_q, gap_d;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        last_grant_q;
  logic [KEY_WIDTH-1:0]    key_q;
  logic [VALUE_WIDTH-1:0]  value_q;
  logic [ADDR_WIDTH-1:0]   addr_q;

  logic [IDX_W-1:0]        cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]      cand_hit;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_found;
  logic                    accept;

  // (base + off) mod NUM_REQ, valid for base, off < NUM_REQ
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W:0]   off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    return sum[IDX_W-1:0];
  endfunction

  // Candidate gi is the requester gi positions above the round-robin pointer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = wrap_idx(ptr_q, (IDX_W+1)'(gi));
      assign cand_hit[gi] = s_req_valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  assign accept = rst_n && (state_q == ST_IDLE) && !cfg_hold && grant_found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign s_req_ready[gi] = accept && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gap_d   = 4'(GAP_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    config_mat_en = (state_q == ST_WRITE);
    busy          = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q        <= '0;
      value_q      <= '0;
      addr_q       <= '0;
      ptr_q        <= '0;
      last_grant_q <= '0;
    end else if (accept) begin
      key_q        <= s_req_key[grant_idx*KEY_WIDTH +: KEY_WIDTH];
      value_q      <= s_req_value[grant_idx*VALUE_WIDTH +: VALUE_WIDTH];
      addr_q       <= s_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      last_grant_q <= grant_idx;
      ptr_q        <= wrap_idx(grant_idx, (IDX_W+1)'(1));
    end
  end

  assign config_mat_key   = key_q;
  assign config_mat_value = value_q;
  assign config_mat_addr  = addr_q;
  assign last_grant       = last_grant_q;

`ifdef PANIC_MAT_CFG_STATS_EN
  logic [31:0] hold_cnt_q;

  // last_grant_q still names the owner of the pulse while in WRITE.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      logic [15:0] wr_cnt_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_cnt_q <= '0;
        end else if ((state_q == ST_WRITE) && (last_grant_q == IDX_W'(gi))
                     && (wr_cnt_q != 16'hFFFF)) begin
          wr_cnt_q <= wr_cnt_q + 16'd1;
        end
      end
      assign stat_wr_cnt[gi*16 +: 16] = wr_cnt_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && cfg_hold && (|s_req_valid)) begin
      hold_cnt_q <= hold_cnt_q + 32'd1;
    end
  end

  assign stat_hold_cycles = hold_cnt_q;
`endif

endmodule

// File: tb/tb_panic_mat_cfg_arbiter.sv
// Randomised + directed bench for panic_mat_cfg_arbiter against a cooldown-based reference model.
module tb_panic_mat_cfg_arbiter;
  localparam int N   = 4;
  localparam int KW  = 32;
  localparam int VW  = 128;
  localparam int AW  = 10;
  localparam int GAP = 1;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_hold = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    ready;
  logic [N*KW-1:0] key_flat = '0;
  logic [N*VW-1:0] val_flat = '0;
  logic [N*AW-1:0] addr_flat = '0;
  logic            en;
  logic [KW-1:0]   key_o;
  logic [VW-1:0]   val_o;
  logic [AW-1:0]   addr_o;
  logic            busy;
  logic [IW-1:0]   lg;
`ifdef PANIC_MAT_CFG_STATS_EN
  logic [N*16-1:0] st_wr;
  logic [31:0]     st_hold;
`endif

  always #5 clk = ~clk;

  panic_mat_cfg_arbiter #(
    .NUM_REQ(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .ADDR_WIDTH(AW),
    .GAP_CYCLES(GAP), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_valid(valid), .s_req_ready(ready),
    .s_req_key(key_flat), .s_req_value(val_flat), .s_req_addr(addr_flat),
    .cfg_hold(cfg_hold),
    .config_mat_en(en), .config_mat_key(key_o), .config_mat_value(val_o),
    .config_mat_addr(addr_o), .busy(busy), .last_grant(lg)
`ifdef PANIC_MAT_CFG_STATS_EN
    , .stat_wr_cnt(st_wr), .stat_hold_cycles(st_hold)
`endif
  );

  // Model: m_wait = cycles until the arbiter may grant again (0 = idle).
  int          m_wait = 0;
  logic        m_en = 1'b0;
  logic [KW-1:0] m_key = '0;
  logic [VW-1:0] m_val = '0;
  logic [AW-1:0] m_addr = '0;
  int          m_lg = 0;
  int          m_ptr = 0;
  int unsigned m_wr [N];
  int unsigned m_hold = 0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int grant_log [$];
  int gcyc_log [$];
  int en_cyc [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gcyc_log.delete();
    en_cyc.delete();
    busy_cnt = 0;
  endtask

  // One cycle: compare at negedge, advance model, step past the posedge.
  task automatic tick();
    logic [N-1:0] exp_ready;
    int g;
    int idx;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && valid[idx]) g = idx;
    end
    exp_ready = '0;
    if (rst_n && m_wait == 0 && !cfg_hold && g >= 0) exp_ready[g] = 1'b1;

    chk("ready", 128'(ready), 128'(exp_ready));
    chk("en", 128'(en), 128'(m_en));
    chk("key", 128'(key_o), 128'(m_key));
    chk("value", val_o, m_val);
    chk("addr", 128'(addr_o), 128'(m_addr));
    chk("busy", 128'(busy), 128'(m_wait > 0));
    chk("last_grant", 128'(lg), 128'(m_lg));
`ifdef PANIC_MAT_CFG_STATS_EN
    for (int i = 0; i < N; i++)
      chk("stat_wr_cnt", 128'(st_wr[i*16 +: 16]), 128'(m_wr[i][15:0]));
    chk("stat_hold", 128'(st_hold), 128'(m_hold));
`endif
    if (m_en) en_cyc.push_back(cyc);
    if (m_wait > 0) busy_cnt++;

    if (!rst_n) begin
      m_wait = 0; m_en = 1'b0; m_key = '0; m_val = '0; m_addr = '0;
      m_lg = 0; m_ptr = 0; m_hold = 0;
      for (int i = 0; i < N; i++) m_wr[i] = 0;
    end else begin
      if (m_en && m_wr[m_lg] < 32'hFFFF) m_wr[m_lg]++;
      if (m_wait == 0 && cfg_hold && valid != '0) m_hold++;
      if (m_wait == 0) begin
        if (exp_ready != '0) begin
          m_en   = 1'b1;
          m_key  = key_flat[g*KW +: KW];
          m_val  = val_flat[g*VW +: VW];
          m_addr = addr_flat[g*AW +: AW];
          m_lg   = g;
          m_ptr  = (g + 1) % N;
          m_wait = 1 + GAP;
          grant_log.push_back(g);
          gcyc_log.push_back(cyc);
          $display("cycle %0d: grant req%0d key=%h addr=%h", cyc, g, m_key, m_addr);
        end else begin
          m_en = 1'b0;
        end
      end else begin
        m_en = 1'b0;
        m_wait--;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_grant(input string nm);
    int n0;
    n0 = grant_log.size();
    for (int t = 0; t < 20 && grant_log.size() == n0; t++) tick();
    chk(nm, 128'(grant_log.size() > n0), 128'(1));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_wr[i] = 0;
    #1;

    // Reset, then a single entry from req0
    reset_pulse();
    chk("rst_en", 128'(en), 128'(0));
    chk("rst_key", 128'(key_o), 128'(0));
    chk("rst_value", val_o, 128'(0));
    chk("rst_addr", 128'(addr_o), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_last_grant", 128'(lg), 128'(0));
    clear_logs();
    valid = 4'b0001;
    key_flat[0 +: KW] = 32'd33;
    addr_flat[0 +: AW] = 10'd5;
    val_flat[0 +: VW] = (128'd1 << 96) | (128'd4 << 32);
    tick();
    valid = '0;
    for (int t = 0; t < 4; t++) tick();
    chk("t1_grant_count", 128'(grant_log.size()), 128'(1));
    chk("t1_grant_idx", 128'(grant_log[0]), 128'(0));
    chk("t1_en_count", 128'(en_cyc.size()), 128'(1));
    chk("t1_latency", 128'(en_cyc[0] - gcyc_log[0]), 128'(1));
    chk("t1_busy_cycles", 128'(busy_cnt), 128'(1 + GAP));
    chk("t1_key", 128'(key_o), 128'(33));
    chk("t1_addr", 128'(addr_o), 128'(5));
    chk("t1_value", val_o, (128'd1 << 96) | (128'd4 << 32));
    chk("t1_last_grant", 128'(lg), 128'(0));

    // req1 + req3 from pointer 0
    reset_pulse();
    clear_logs();
    valid = 4'b1010;
    for (int t = 0; t < 30 && grant_log.size() < 2; t++) begin
      tick();
      if (grant_log.size() > 0) valid[grant_log[grant_log.size()-1]] = 1'b0;
    end
    for (int t = 0; t < 4; t++) tick();
    chk("t2_grants", 128'(grant_log.size()), 128'(2));
    chk("t2_first", 128'(grant_log[0]), 128'(1));
    chk("t2_second", 128'(grant_log[1]), 128'(3));
    chk("t2_en_spacing", 128'(en_cyc[1] - en_cyc[0]), 128'(2 + GAP));
    chk("t2_ptr", 128'(m_ptr), 128'(0));

    // All four continuously valid for 12 writes
    clear_logs();
    valid = 4'b1111;
    for (int t = 0; t < 100 && grant_log.size() < 12; t++) tick();
    valid = '0;
    for (int t = 0; t < 4; t++) tick();
    chk("t3_grants", 128'(grant_log.size()), 128'(12));
    chk("t3_en_pulses", 128'(en_cyc.size()), 128'(12));
    for (int i = 0; i < 12 && i < grant_log.size(); i++)
      chk("t3_order", 128'(grant_log[i]), 128'(i % N));
    for (int i = 1; i < en_cyc.size(); i++)
      chk("t3_spacing", 128'(en_cyc[i] - en_cyc[i-1]), 128'(2 + GAP));

    // cfg_hold raised right after req2 is accepted
    clear_logs();
    valid = 4'b0100;
    wait_grant("t4_req2_grant");
    cfg_hold = 1'b1;
    valid = 4'b0001;
    tick();
    chk("t4_pulse_under_hold", 128'(en_cyc.size()), 128'(1));
    for (int t = 0; t < 6; t++) tick();
    chk("t4_no_grant_held", 128'(grant_log.size()), 128'(1));
    cfg_hold = 1'b0;
    tick();
    chk("t4_grant_after_release", 128'(grant_log.size()), 128'(2));
    chk("t4_req0_granted", 128'(grant_log[grant_log.size()-1]), 128'(0));
    valid = '0;
    for (int t = 0; t < 4; t++) tick();

    // Reset lands on the WRITE cycle
    clear_logs();
    key_flat[KW +: KW] = 32'hDEAD_BEEF;
    valid = 4'b0010;
    wait_grant("t5_req1_grant");
    valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_en_cleared", 128'(en), 128'(0));
    chk("t5_key_cleared", 128'(key_o), 128'(0));
    chk("t5_busy_cleared", 128'(busy), 128'(0));
    chk("t5_lg_cleared", 128'(lg), 128'(0));
    for (int t = 0; t < 4; t++) tick();
    chk("t5_not_reserved", 128'(grant_log.size()), 128'(1));

    // Randomised traffic
    for (int t = 0; t < 400; t++) begin
      valid = N'($urandom_range(0, (1 << N) - 1));
      cfg_hold = ($urandom_range(0, 9) < 2);
      rst_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++) begin
        key_flat[i*KW +: KW] = $urandom;
        val_flat[i*VW +: VW] = {$urandom, $urandom, $urandom, $urandom};
        addr_flat[i*AW +: AW] = AW'($urandom);
      end
      tick();
    end
    rst_n = 1'b1;
    valid = '0;
    cfg_hold = 1'b0;
    for (int t = 0; t < 4; t++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
